// File: rtl/tinyml_mem_pkg.sv
// rtl/tinyml_mem_pkg.sv - shared types and helpers for the byte-serial memory paths
package tinyml_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } store_state_t;

  // Words travel MSB-first: byte k of a word sits at word[(nb-1-k)*dw +: dw]
  // and lives at base address + k, matching the fetch path.
  function automatic int bytes_per_word(input int word_width, input int data_width);
    return word_width / data_width;
  endfunction

endpackage

// File: rtl/byte_serializer.sv
// rtl/byte_serializer.sv - load/shift register presenting its most significant byte
module byte_serializer #(
  parameter int WORD_WIDTH = 64,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic [WORD_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] top_o
);

  logic [WORD_WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      sr_d = sr_q << DATA_WIDTH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign top_o = sr_q[WORD_WIDTH-1 -: DATA_WIDTH];

endmodule

// File: rtl/byte_store_unit.sv
// rtl/byte_store_unit.sv - writes one wide word into byte-wide memory, MSB byte first
module byte_store_unit
  import tinyml_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 8,
  parameter int WORD_WIDTH = 64,
  localparam int NB = bytes_per_word(WORD_WIDTH, DATA_WIDTH),
  localparam int CW = $clog2(NB) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WORD_WIDTH-1:0] data_i,
  input  logic [CW-1:0]         len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_din_o
);

  store_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         len_clamped;
  logic                  load, shift;

  assign len_clamped = (len_i > CW'(NB)) ? CW'(NB) : len_i;

  // Address and data are only reloaded for non-empty requests, and nothing
  // advances on the final byte, so the memory-side outputs hold while idle.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          cnt_d = len_clamped;
          if (len_clamped != '0) begin
            load    = 1'b1;
            addr_d  = addr_i;
            state_d = S_WRITE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_WRITE: begin
        if (cnt_q == CW'(1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          shift  = 1'b1;
          addr_d = addr_q + ADDR_WIDTH'(1);
          cnt_d  = cnt_q - CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  byte_serializer #(
    .WORD_WIDTH(WORD_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ser (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .shift_i(shift),
    .data_i (data_i),
    .top_o  (mem_din_o)
  );

  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);
  assign mem_we_o   = (state_q == S_WRITE);
  assign mem_addr_o = addr_q;

endmodule

// File: tb/tb_byte_store_unit.sv
// tb/tb_byte_store_unit.sv - directed self-checking bench for byte_store_unit
module tb_byte_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [23:0] addr_i = '0;
  logic [63:0] data_i = '0;
  logic [3:0]  len_i = '0;
  logic        busy_o, done_o, mem_we_o;
  logic [23:0] mem_addr_o;
  logic [7:0]  mem_din_o;

  byte_store_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .addr_i    (addr_i),
    .data_i    (data_i),
    .len_i     (len_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .mem_we_o  (mem_we_o),
    .mem_addr_o(mem_addr_o),
    .mem_din_o (mem_din_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [7:0]  mem [int];
  logic [23:0] wr_addr_q [$];
  logic [7:0]  wr_data_q [$];
  int          wr_cyc_q  [$];
  int          done_cyc_q[$];
  bit          busy_hist [int];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we_o) mem[int'(mem_addr_o)] = mem_din_o;
  end

  always @(negedge clk) begin
    busy_hist[cyc] = busy_o;
    if (mem_we_o) begin
      wr_addr_q.push_back(mem_addr_o);
      wr_data_q.push_back(mem_din_o);
      wr_cyc_q.push_back(cyc);
    end
    if (done_o) done_cyc_q.push_back(cyc);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic logic [7:0] rd(input int a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] byte_of(input logic [63:0] d, input int k);
    logic [63:0] s;
    s = d >> ((7 - k) * 8);
    return s[7:0];
  endfunction

  task automatic do_store(input string name, input logic [23:0] a, input logic [63:0] d,
                          input logic [3:0] len, input int exp_n, input bit ign);
    int acc;
    @(negedge clk);
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete(); done_cyc_q.delete();
    start_i = 1'b1; addr_i = a; data_i = d; len_i = len;
    @(posedge clk);
    #1 acc = cyc;
    for (int i = 0; i < exp_n + 4; i++) begin
      @(negedge clk);
      start_i = ign && (cyc == acc + 2 || cyc == acc + exp_n);
      data_i  = ~d;
      addr_i  = a + 24'h100;
    end
    start_i = 1'b0;
    check({name, "_nwr"}, 64'(wr_addr_q.size()), 64'(exp_n));
    for (int k = 0; k < exp_n && k < wr_addr_q.size(); k++) begin
      check($sformatf("%s_addr%0d", name, k), 64'(wr_addr_q[k]), 64'(24'(a + 24'(k))));
      check($sformatf("%s_data%0d", name, k), 64'(wr_data_q[k]), 64'(byte_of(d, k)));
      check($sformatf("%s_cyc%0d", name, k), 64'(wr_cyc_q[k]), 64'(acc + k));
    end
    check({name, "_ndone"}, 64'(done_cyc_q.size()), 64'd1);
    if (done_cyc_q.size() > 0) check({name, "_donecyc"}, 64'(done_cyc_q[0]), 64'(acc + exp_n));
    check({name, "_busy_done"}, 64'(busy_hist[acc + exp_n]), 64'd1);
    check({name, "_busy_after"}, 64'(busy_hist[acc + exp_n + 1]), 64'd0);
  endtask

  initial begin
    int acc;
    logic [63:0] rt;

    #12;
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_we", 64'(mem_we_o), 64'd0);
    check("rst_addr", 64'(mem_addr_o), 64'd0);
    check("rst_din", 64'(mem_din_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_store("full", 24'h000010, 64'h0123456789ABCDEF, 4'd8, 8, 1'b0);
    check("full_m10", 64'(rd(32'h10)), 64'h01);
    check("full_m11", 64'(rd(32'h11)), 64'h23);
    check("full_m17", 64'(rd(32'h17)), 64'hEF);

    mem[32'h23] = 8'h5A;
    do_store("part", 24'h000020, 64'hAABBCCDD11223344, 4'd3, 3, 1'b0);
    check("part_m22", 64'(rd(32'h22)), 64'hCC);
    check("part_m23", 64'(rd(32'h23)), 64'h5A);

    do_store("zero", 24'h000030, 64'h1111111111111111, 4'd0, 0, 1'b0);
    do_store("clamp", 24'h000060, 64'h0F1E2D3C4B5A6978, 4'd12, 8, 1'b0);
    check("clamp_m68", 64'(rd(32'h68)), 64'h00);

    do_store("wrap", 24'hFFFFFE, 64'h1122334455667788, 4'd4, 4, 1'b0);
    check("wrap_mfffffe", 64'(rd(32'hFFFFFE)), 64'h11);
    check("wrap_m000001", 64'(rd(32'h000001)), 64'h44);

    do_store("rt", 24'h000000, 64'hDEADBEEFCAFEF00D, 4'd8, 8, 1'b0);
    rt = '0;
    for (int k = 0; k < 8; k++) rt = {rt[55:0], rd(k)};
    check("rt_fetch", rt, 64'hDEADBEEFCAFEF00D);

    do_store("ign", 24'h000080, 64'h8877665544332211, 4'd8, 8, 1'b1);
    check("ign_m80", 64'(rd(32'h80)), 64'h88);
    check("ign_m87", 64'(rd(32'h87)), 64'h11);

    for (int k = 0; k < 8; k++) mem[32'h40 + k] = 8'hEE;
    @(negedge clk);
    start_i = 1'b1; addr_i = 24'h000040; data_i = 64'hA1A2A3A4A5A6A7A8; len_i = 4'd8;
    @(posedge clk);
    #1 acc = cyc;
    @(negedge clk);
    start_i = 1'b0;
    while (cyc < acc + 3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_busy", 64'(busy_o), 64'd0);
    check("mid_done", 64'(done_o), 64'd0);
    check("mid_we", 64'(mem_we_o), 64'd0);
    check("mid_addr", 64'(mem_addr_o), 64'd0);
    check("mid_din", 64'(mem_din_o), 64'd0);
    repeat (2) @(negedge clk);
    check("mid_m40", 64'(rd(32'h40)), 64'hA1);
    check("mid_m42", 64'(rd(32'h42)), 64'hA3);
    check("mid_m43", 64'(rd(32'h43)), 64'hEE);
    check("mid_m47", 64'(rd(32'h47)), 64'hEE);
    rst_n = 1'b1;
    do_store("post", 24'h000050, 64'h5152535455565758, 4'd2, 2, 1'b0);
    check("post_m43", 64'(rd(32'h43)), 64'hEE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/byte_store_unit.md
Name: byte_store_unit

Overview:
- Write-side counterpart of the byte-serial instruction fetch path.
- Accepts one wide word plus a base address. Writes it into the byte-wide simple_memory write port one byte per cycle, MSB byte first at the lowest address.
- A word written at address A by this block is read back unchanged by the fetch path starting at A.
- Used by the loader/host path to place instructions and data into DRAM model memory.

Parameters:
- ADDR_WIDTH, 24, byte address width, equal to the simple_memory address width
- DATA_WIDTH, 8, memory data width in bits; byte writes
- WORD_WIDTH, 64, input word width; must be a multiple of DATA_WIDTH; NB = WORD_WIDTH/DATA_WIDTH

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  request pulse/level; sampled only in IDLE
- addr_i  in  ADDR_WIDTH  base byte address, latched on accept
- data_i  in  WORD_WIDTH  word to store, latched on accept
- len_i  in  $clog2(NB)+1  bytes to write, latched on accept; 0 allowed, values >NB clamp to NB
- busy_o  out  1  high whenever state != IDLE
- done_o  out  1  one-cycle completion pulse
- mem_we_o  out  1  write enable to simple_memory
- mem_addr_o  out  ADDR_WIDTH  write address
- mem_din_o  out  DATA_WIDTH  write data

Behaviour:
- Reset (async, any state, including mid-transfer):
  - state=IDLE; busy_o, done_o, mem_we_o = 0; mem_addr_o, mem_din_o = 0.
  - Latched address, shift register and counter are cleared.
  - No further writes are issued after reset asserts.
- States:
  - IDLE: start_i=1 latches addr_i, data_i and the clamped len_i into cnt.
    - Next state is WRITE if len>0, else DONE.
    - start_i while not IDLE is ignored and never queued.
  - WRITE: one byte per cycle.
    - mem_we_o=1, mem_addr_o=current addr, mem_din_o=top DATA_WIDTH bits of the shift register.
    - At each edge: shift register shifts left by DATA_WIDTH, addr increments by 1, cnt decrements.
    - When cnt==1 at the edge, go to DONE.
  - DONE: done_o=1 for exactly one cycle, mem_we_o=0, then IDLE.
- Outputs are driven from registers/state only; no combinational path from inputs to outputs.
- Timing, with start accepted at edge t:
  - Write cycles occupy t+1 .. t+len; each write commits at the end of its cycle.
  - done_o is high in cycle t+len+1.
  - busy_o is high from t+1 through the done cycle.
  - A new start is accepted at the earliest in the first IDLE cycle after done. Back-to-back throughput is NB+2 cycles per word.
- Byte order:
  - Byte k (0-based) = data_i[(NB-1-k)*DATA_WIDTH +: DATA_WIDTH], written at addr_i+k.
  - Partial length (len<NB) writes the len most-significant bytes.
- Address arithmetic: modulo 2^ADDR_WIDTH. Incrementing past all-ones wraps to 0 silently.
- len=0: no write cycles; done_o fires in cycle t+1.
- done_o and start_i in the same cycle: start_i is ignored (state is DONE, not IDLE).
- mem_din_o and mem_addr_o hold their last values when mem_we_o=0. Verification checks them only while mem_we_o=1.

Decomposition:
- Shared package tinyml_mem_pkg:
  - store_state_t enum {S_IDLE, S_WRITE, S_DONE}
  - BYTES_PER_WORD localparam function
  - the byte-ordering convention (MSB-first)
- Optional sub-module byte_serializer:
  - load/shift register, WORD_WIDTH wide, exposing the top byte
  - reusable later by a DMA write path
- Controller FSM stays in byte_store_unit.

Test Plan:
- Full word: start with addr=0x000010, data=0x0123456789ABCDEF, len=8.
  - Expect 8 consecutive write cycles: 0x10←01, 0x11←23, … 0x17←EF.
  - done_o in cycle 9 after accept; memory readback matches.
- Round trip: store 0xDEADBEEFCAFEF00D at 0, then run the fetch path from pc=0 → instruction equals 0xDEADBEEFCAFEF00D.
- Partial and zero length:
  - len=3, data=0xAABBCCDD11223344 at 0x20 → writes only 0x20←AA, 0x21←BB, 0x22←CC; 0x23 unchanged.
  - len=0 → no mem_we_o, done_o 1 cycle after accept.
  - len=12 → clamped to 8 writes.
- Wrap: addr=0xFFFFFE, len=4, data=0x11223344_xxxxxxxx → 0xFFFFFE←11, 0xFFFFFF←22, 0x000000←33, 0x000001←44.
- Ignored start: pulse start_i with a different word during WRITE and again during the done cycle.
  - Only the first word is written; exactly one done_o pulse; busy_o drops on the cycle after done.
- Reset mid-op: deassert rst_n asynchronously after 3 of 8 writes.
  - All outputs go to 0 immediately; only addrs base..base+2 are modified.
  - After release the block is in IDLE and accepts a new start normally.
